// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit period and the TX state encoding.
// PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int UART_DATA_W       = 8;
   localparam int UART_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd5,
`endif
      STOP   = 3'd6
   } uart_state_e;

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: load restarts a full period, tick marks the last cycle of the period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(CLKS_PER_BIT - 1);
      end else if (cnt_q != {CNT_W{1'b0}}) begin
         cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/uart_tx.sv
// UART transmitter pulling bytes from an upstream FIFO: 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [UART_DATA_W-1:0] data_in,
   input  logic                   fifo_empty,
   output logic                   en_read,
   output logic                   tx,
   output logic                   busy
);

   uart_state_e            state_q;
   uart_state_e            state_d;
   logic [UART_DATA_W-1:0] shreg_q;
   logic [UART_DATA_W-1:0] shreg_d;
   logic [2:0]             idx_q;
   logic [2:0]             idx_d;
   logic                   tx_q;
   logic                   tx_d;
   logic                   bit_load;
   logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
   logic                   par_q;
   logic                   par_d;
`endif

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk  (clk),
      .reset(reset),
      .load (bit_load),
      .tick (bit_tick)
   );

   // Every bit entry reloads the timer, so each bit lasts exactly CLKS_PER_BIT cycles.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      bit_load = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            shreg_d  = data_in;
`ifdef UART_TX_PARITY_EN
            par_d    = even_parity(data_in);
`endif
            bit_load = 1'b1;
            state_d  = START;
         end
         START: begin
            if (bit_tick) begin
               bit_load = 1'b1;
               state_d  = DATA;
            end else begin
               state_d  = START;
            end
         end
         DATA: begin
            if (bit_tick) begin
               bit_load = 1'b1;
               idx_d    = idx_q + 3'd1;
               shreg_d  = {1'b0, shreg_q[UART_DATA_W-1:1]};
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               bit_load = 1'b1;
               state_d  = STOP;
            end else begin
               state_d  = PARITY;
            end
         end
`endif
         STOP: begin
            if (bit_tick) begin
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line level is derived from the next state so tx changes on the same edge as the state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= {UART_DATA_W{1'b0}};
         idx_q   <= 3'd0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign en_read = (state_q == FETCH);
   assign busy    = (state_q != IDLE);
   assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model + expected-byte scoreboard, line monitor decodes frames.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int N  = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * N;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       fifo_empty;
   logic       en_read;
   logic       tx;
   logic       busy;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(.CLKS_PER_BIT(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .fifo_empty(fifo_empty),
      .en_read   (en_read),
      .tx        (tx),
      .busy      (busy)
   );

   // stimulus-side state (written only by the main process)
   logic [7:0] fq[$];
   logic [7:0] exp_mem[256];
   int         exp_wr = 0;
   int         en_cnt = 0;
   bit         tog = 1'b0;
   int         main_cmp = 0;
   int         main_fail = 0;

   // monitor-side state (written only by the monitor process)
   int         mon_cmp = 0;
   int         mon_fail = 0;
   int         rd = 0;
   int         frames_done = 0;
   int         last_gap = -1;
   int         prev_end = 0;
   bit         prev_vld = 1'b0;
   bit         in_frame = 1'b0;
   bit         pend_end = 1'b0;
   int         k = 0;
   logic       smp[FL];

   // Reference frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic exp_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (NB == 11 && b == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic step();
      @(negedge clk);
      if (en_read === 1'b1) begin
         en_cnt++;
         if (fq.size() > 0) data_in = fq.pop_front();
      end
      fifo_empty = tog ? cyc[0] : (fq.size() == 0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      main_cmp++;
      if (act !== expv) begin
         main_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      fq.push_back(b);
      exp_mem[exp_wr % 256] = b;
      exp_wr++;
   endtask

   task automatic wait_frames(input string name, input int target, input int budget);
      int t = 0;
      while (frames_done < target && t < budget) begin
         step();
         t++;
      end
      check(name, 32'(frames_done >= target), 32'd1);
   endtask

   task automatic wait_tx_low(input string name, input int budget);
      int t = 0;
      while (tx !== 1'b0 && t < budget) begin
         step();
         t++;
      end
      check(name, 32'(tx === 1'b0), 32'd1);
   endtask

   // Monitor: decode each frame off the line and compare it with the next expected byte.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset === 1'b1) begin
            if (in_frame) rd++;
            in_frame = 1'b0;
            pend_end = 1'b0;
            prev_vld = 1'b0;
         end else if (pend_end) begin
            pend_end = 1'b0;
            mon_cmp++;
            if (busy !== 1'b0) begin
               mon_fail++;
               $display("FAIL stop_exit_busy frame %0d: busy=%b, expected 0", frames_done, busy);
            end
            frames_done++;
         end else if (!in_frame) begin
            if (tx === 1'b0) begin
               in_frame = 1'b1;
               smp[0]   = tx;
               k        = 1;
               if (prev_vld) last_gap = cyc - prev_end;
               mon_cmp++;
               if (rd >= exp_wr) begin
                  mon_fail++;
                  $display("FAIL unexpected_frame: frame %0d started, only %0d bytes queued", rd, exp_wr);
               end
            end
         end else begin
            smp[k] = tx;
            k++;
            if (k == FL) begin
               for (int b = 0; b < NB; b++) begin
                  logic e;
                  int   bad;
                  e   = exp_bit(exp_mem[rd % 256], b);
                  bad = -1;
                  for (int s = 0; s < N; s++)
                     if (bad < 0 && smp[b*N+s] !== e) bad = s;
                  mon_cmp++;
                  if (bad >= 0) begin
                     mon_fail++;
                     $display("FAIL frame%0d_bit%0d (byte %02h): got %b at sample %0d, expected %b",
                              rd, b, exp_mem[rd % 256], smp[b*N+bad], bad, e);
                  end
               end
               in_frame = 1'b0;
               pend_end = 1'b1;
               prev_end = cyc;
               prev_vld = 1'b1;
               rd++;
            end
         end
      end
   end

   initial begin
      int e0;
      int ne;
      int nt;
      int nb;
      int fd;
      reset      = 1'b1;
      data_in    = 8'h00;
      fifo_empty = 1'b1;
      repeat (3) step();
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_en_read", 32'(en_read), 32'd0);
      reset = 1'b0;

      // empty FIFO: nothing happens
      ne = 0; nt = 0; nb = 0;
      repeat (500) begin
         step();
         if (en_read !== 1'b0) ne++;
         if (tx !== 1'b1) nt++;
         if (busy !== 1'b0) nb++;
      end
      check("idle_en_read_cycles", 32'(ne), 32'd0);
      check("idle_tx_low_cycles", 32'(nt), 32'd0);
      check("idle_busy_cycles", 32'(nb), 32'd0);

      // single 0x55
      fd = frames_done; e0 = en_cnt;
      push_byte(8'h55);
      wait_frames("frame_55_done", fd + 1, 400);
      step();
      check("en_read_55", 32'(en_cnt - e0), 32'd1);

      // back-to-back 0xA3, 0x0F
      fd = frames_done; e0 = en_cnt;
      push_byte(8'hA3);
      push_byte(8'h0F);
      wait_frames("frames_a3_0f_done", fd + 2, 800);
      step();
      check("en_read_a3_0f", 32'(en_cnt - e0), 32'd2);
      check("b2b_start_gap", 32'(last_gap), 32'd4);

`ifdef UART_TX_PARITY_EN
      fd = frames_done;
      push_byte(8'h07);
      push_byte(8'h55);
      wait_frames("parity_frames_done", fd + 2, 800);
`endif

      // fifo_empty toggling mid-DATA
      fd = frames_done; e0 = en_cnt;
      push_byte(8'h96);
      wait_tx_low("toggle_frame_start", 100);
      repeat (40) step();
      tog = 1'b1;
      repeat (80) step();
      tog = 1'b0;
      wait_frames("toggle_frame_done", fd + 1, 400);
      repeat (5) step();
      check("en_read_toggle", 32'(en_cnt - e0), 32'd1);

      // randomized bursts
      fd = frames_done; e0 = en_cnt;
      for (int i = 0; i < 16; i++) begin
         push_byte(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 30)) step();
      end
      wait_frames("random_frames_done", fd + 16, 16 * 220 + 600);
      step();
      check("en_read_random", 32'(en_cnt - e0), 32'd16);

      // reset at cycle 70 of a 0xFF frame
      fd = frames_done;
      push_byte(8'hFF);
      wait_tx_low("ff_frame_start", 100);
      repeat (69) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_en_read", 32'(en_read), 32'd0);
      e0 = en_cnt; nt = 0;
      repeat (200) begin
         step();
         if (tx !== 1'b1) nt++;
      end
      check("abort_no_en_read", 32'(en_cnt - e0), 32'd0);
      check("abort_no_resend", 32'(nt), 32'd0);
      push_byte(8'h3C);
      wait_frames("post_abort_frame_done", fd + 1, 400);
      step();
      check("en_read_post_abort", 32'(en_cnt - e0), 32'd1);
      check("all_frames_seen", 32'(rd), 32'(exp_wr));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", main_cmp + mon_cmp, main_fail + mon_fail);
      $finish;
   end

endmodule
